reg_wb_arbiter: RTL

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/wb_pkg.sv | 11 +
 rtl/wb_slot.sv | 37 +++
 rtl/reg_wb_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register write-back arbiter.
package wb_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ALU = 2'd1,
    WR_MEM = 2'd2
  } wb_state_e;
endpackage

// File: rtl/wb_slot.sv
// One-entry holding slot for a pending register write.
module wb_slot
  import wb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic [REG_DATA_W-1:0] data_i,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] addr_o,
  output logic [REG_DATA_W-1:0] data_o
);
  logic                  valid_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [REG_DATA_W-1:0] data_q;

  // load only happens while empty and clear only while full, so they never collide
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates ALU and load write-backs into a single register-file write port,
// committing in age order and stalling on BUSYWAIT.
module reg_wb_arbiter
  import wb_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ALU_VALID,
  input  logic [REG_ADDR_W-1:0] ALU_ADDR,
  input  logic [REG_DATA_W-1:0] ALU_DATA,
  output logic                  ALU_READY,
  input  logic                  MEM_VALID,
  input  logic [REG_ADDR_W-1:0] MEM_ADDR,
  input  logic [REG_DATA_W-1:0] MEM_DATA,
  output logic                  MEM_READY,
  input  logic                  BUSYWAIT,
  output logic                  WRITE,
  output logic [REG_ADDR_W-1:0] INADDRESS,
  output logic [REG_DATA_W-1:0] IN,
  output logic [1:0]            PENDING,
  output wb_state_e             DBG_STATE
);
  // Handshake: a request transfers on a rising CLK where VALID and READY are
  // both high; READY is simply "slot empty", so VALID never feeds READY.

  wb_state_e             state_q, state_d;
  logic                  mem_older_q, mem_older_d;
  logic                  alu_v, mem_v;
  logic [REG_ADDR_W-1:0] alu_a, mem_a;
  logic [REG_DATA_W-1:0] alu_d, mem_d;
  logic                  alu_load, mem_load, alu_clr, mem_clr, commit;
  logic                  alu_stay, mem_stay, alu_nv, mem_nv;

  assign ALU_READY = !alu_v;
  assign MEM_READY = !mem_v;
  assign alu_load  = ALU_VALID && ALU_READY;
  assign mem_load  = MEM_VALID && MEM_READY;
  assign commit    = (state_q != IDLE) && !BUSYWAIT;
  assign alu_clr   = commit && (state_q == WR_ALU);
  assign mem_clr   = commit && (state_q == WR_MEM);

  wb_slot u_alu_slot (
    .clk_i(CLK), .rst_ni(RESET_N), .load_i(alu_load), .clear_i(alu_clr),
    .addr_i(ALU_ADDR), .data_i(ALU_DATA),
    .valid_o(alu_v), .addr_o(alu_a), .data_o(alu_d)
  );

  wb_slot u_mem_slot (
    .clk_i(CLK), .rst_ni(RESET_N), .load_i(mem_load), .clear_i(mem_clr),
    .addr_i(MEM_ADDR), .data_i(MEM_DATA),
    .valid_o(mem_v), .addr_o(mem_a), .data_o(mem_d)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      mem_older_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_older_q <= mem_older_d;
    end
  end

  // Next state sees the slot contents as they will be after this edge.
  always_comb begin
    state_d     = state_q;
    mem_older_d = mem_older_q;
    alu_stay    = alu_v && !alu_clr;
    mem_stay    = mem_v && !mem_clr;
    alu_nv      = alu_stay || alu_load;
    mem_nv      = mem_stay || mem_load;

    if (alu_load && mem_load)      mem_older_d = 1'b1;
    else if (alu_load && mem_stay) mem_older_d = 1'b1;
    else if (mem_load && alu_stay) mem_older_d = 1'b0;

    if (state_q == IDLE || commit) begin
      if (alu_nv && mem_nv) state_d = mem_older_d ? WR_MEM : WR_ALU;
      else if (alu_nv)      state_d = WR_ALU;
      else if (mem_nv)      state_d = WR_MEM;
      else                  state_d = IDLE;
    end
  end

  always_comb begin
    WRITE     = 1'b0;
    INADDRESS = '0;
    IN        = '0;
    case (state_q)
      WR_ALU: begin
        WRITE     = 1'b1;
        INADDRESS = alu_a;
        IN        = alu_d;
      end
      WR_MEM: begin
        WRITE     = 1'b1;
        INADDRESS = mem_a;
        IN        = mem_d;
      end
      default: ;
    endcase
  end

  assign PENDING   = {1'b0, alu_v} + {1'b0, mem_v};
  assign DBG_STATE = state_q;
endmodule
